// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the
// valid/ready decode handshake. master = fetch_queue, slave = memory/decode.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_ins;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_ins, id_pc,
        input  imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ins, id_pc,
        output imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues requests to a 1-cycle
// synchronous instruction memory, buffers {ins, pc} pairs in a small queue
// and hands them to decode over valid/ready. init/redirect flush the queue
// and discard any response arriving in the same cycle.
// Optional macro FETCH_MISALIGN_TRAP_EN: adds fetch_fault and stalls fetch
// on a misaligned init/redirect target instead of forcing alignment.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic [XLEN-1:0]    entry_point,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    fetch_queue_if.master      bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic               fetch_fault
`endif
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [AW:0]     occ_q, occ_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] slot_ins_q [DEPTH];
    logic [XLEN-1:0] slot_ins_d [DEPTH];
    logic [XLEN-1:0] slot_pc_q  [DEPTH];
    logic [XLEN-1:0] slot_pc_d  [DEPTH];
    logic [XLEN-1:0] last_ins_q, last_ins_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;

    logic            kill;
    logic [XLEN-1:0] target;
    logic            head_valid;
    logic [XLEN-1:0] head_ins;
    logic [XLEN-1:0] head_pc;
    logic            pop;
    logic            push;
    logic [AW+1:0]   need;
    logic            req;
    logic            fetch_block;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    // Fault flag: set/cleared only by the alignment of each new init/redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign fault_d     = kill ? (target[1:0] != 2'b00) : fault_q;
    assign fetch_block = fault_q;
    assign fetch_fault = fault_q;
`else
    assign fetch_block = 1'b0;
`endif

    // Handshake, credit check and head-of-queue selection
    always_comb begin
        kill       = init | redirect;
        target     = init ? entry_point : redirect_pc;
        head_valid = (occ_q != '0);
        // When empty the outputs replay whatever was shown last cycle
        head_ins   = head_valid ? slot_ins_q[rd_ptr_q] : last_ins_q;
        head_pc    = head_valid ? slot_pc_q[rd_ptr_q]  : last_pc_q;
        pop        = head_valid & bus.id_ready;
        push       = inflight_q & ~kill;
        // Slots already owned (queued + in flight) minus the one leaving now
        need       = {1'b0, occ_q} + (AW+2)'(inflight_q) - (AW+2)'(pop);
        req        = rst_n & ~kill & ~fetch_block & (need < (AW+2)'(DEPTH));
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = head_valid;
    assign bus.id_ins    = head_ins;
    assign bus.id_pc     = head_pc;

    // PC sequencing and in-flight tracking
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (kill) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = target;
`else
            pc_d = target & ~XLEN'(3);
`endif
        end else if (req) begin
            pc_d       = pc_q + XLEN'(4);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    // Queue storage, pointers and occupancy
    always_comb begin
        slot_ins_d = slot_ins_q;
        slot_pc_d  = slot_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        last_ins_d = head_ins;
        last_pc_d  = head_pc;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                slot_ins_d[wr_ptr_q] = bus.imem_rdata;
                slot_pc_d[wr_ptr_q]  = req_pc_q;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_ins_q <= '0;
            last_pc_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_ins_q[i] <= '0;
                slot_pc_q[i]  <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_ins_q <= last_ins_d;
            last_pc_q  <= last_pc_d;
            slot_ins_q <= slot_ins_d;
            slot_pc_q  <= slot_pc_d;
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end for the pipelined RISC-V core; sits directly upstream of decode (yID) inside yChip.
- Owns the PC and issues requests to a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions with their PCs in a small queue.
- Presents them to decode over a valid/ready handshake; supports entry-point init and EX-stage redirect with wrong-path kill.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 2, queue entries (power of two, 2..8)
RESET_PC, 0, PC value loaded by rst_n

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
init  in  1  sync init strobe: PC <= entry_point, flush queue and in-flight
entry_point  in  XLEN  program entry address (e.g. 128)
redirect  in  1  branch/jump taken in EX
redirect_pc  in  XLEN  redirect target
imem_req  out  1  fetch request this cycle; memory always accepts
imem_addr  out  XLEN  fetch address (= pc)
imem_rdata  in  XLEN  instruction, valid exactly one cycle after an accepted req
id_valid  out  1  queue head valid
id_ready  in  1  decode accepts head
id_ins  out  XLEN  head instruction
id_pc  out  XLEN  head PC

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC; queue empty; inflight=0.
  - imem_req=0, id_valid=0, id_ins=0, id_pc=0.
  - First request is issued in the first cycle after release.
- Priority each cycle: init > redirect > normal fetch.
- pop = id_valid & id_ready. A transfer in a redirect/init cycle still completes; the redirect source squashes it.
- Request issue:
  - imem_req=1 iff no init/redirect this cycle and occ + inflight - pop < DEPTH.
  - On req: imem_addr=pc; pc<=pc+4, mod 2^XLEN (0xFFFFFFFC wraps to 0); req_pc<=pc; inflight<=1.
- Response:
  - Cycle after a req, {imem_rdata, req_pc} is written at the queue tail at the clock edge, unless killed.
  - Queue never overflows; this is guaranteed by the credit rule.
- Kill (init or redirect):
  - Queue flushed (occ=0).
  - Any response arriving this cycle is discarded; inflight<=0.
  - pc<=entry_point (init) or redirect_pc (redirect).
- Latency:
  - Kill at cycle N -> imem_req with new addr at N+1 -> rdata at N+2 -> id_valid at N+3.
  - No bypass: id_valid, id_ins and id_pc come from queue registers only, no combinational path from imem_rdata or redirect.
- Throughput: 1 instruction/cycle sustained while id_ready=1.
- Backpressure:
  - id_ready=0 holds the head stable: id_ins/id_pc unchanged while id_valid & !id_ready.
  - Requests stop when credit is exhausted.
- When empty: id_valid=0; id_ins/id_pc hold their last values.
- Simultaneous pop and write: both occur; occ unchanged.
- Pop on a full queue frees a credit the same cycle.
- Pointers: log2(DEPTH)-bit wrap-around plus a separate occupancy counter of log2(DEPTH)+1 bits.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: adds output fetch_fault (1 bit, reset 0) and checks alignment.
  - On init/redirect with target[1:0]!=0: fetch_fault<=1, pc loaded unmodified, imem_req held 0.
  - fetch_fault stays set until the next aligned init/redirect or reset.
  - Queue still drains normally while fetch_fault is set.
- Undefined: no fetch_fault port; target[1:0] forced to 00 when loaded into pc.

Test Plan:
- Reset release with RESET_PC=0, id_ready=1, memory returning addr>>2 -> imem_addr 0,4,8,... on consecutive cycles; id_valid from cycle 2; id_pc 0,4,8 with id_ins 0,1,2, one per cycle.
- init=1, entry_point=128 for one cycle mid-stream -> queue flushed; next imem_addr=128; first id_pc=128 three cycles after init; no stale PC appears.
- id_ready=0 for 5 cycles -> occ reaches 2; imem_req=0 thereafter; head id_pc/id_ins stable; on id_ready=1, in-order delivery resumes with no lost or duplicate PC.
- redirect=1, redirect_pc=0x200 in the same cycle a response arrives and id_ready=1 -> response dropped; id_valid=0 for 2 cycles; next id_pc=0x200.
- pc=0xFFFFFFFC -> next imem_addr=0x00000000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> fetch_fault=1, imem_req=0; then redirect_pc=0x104 -> fetch_fault=0, fetch resumes at 0x104.
